// File: rtl/fxp_accumulator.sv
// ---------------------------------------------------------------------------
// fxp_accumulator
//
// Purpose:
//   Sums (or differences) ACC_LEN signed fixed-point samples into one result
//   frame. Each step is evaluated exactly in DATA_WIDTH+1 bits, so both
//   out-of-range directions can be detected. Each out-of-range step either
//   saturates (SATURATE=1) or wraps (SATURATE=0), and it also sets a sticky
//   flag for the frame. The arithmetic ignores the binary point, so
//   FIXED_PNT only documents the number format.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst_n         in   synchronous active-low reset
//   in_valid      in   in_data / in_sub are valid
//   in_ready      out  block can accept a sample (low only while a result waits)
//   in_data       in   signed sample, DATA_WIDTH bits
//   in_sub        in   1 = subtract sample, 0 = add sample
//   out_valid     out  result valid (state is HOLD)
//   out_ready     in   consumer accepts the result (ignored outside HOLD)
//   out_data      out  signed accumulated result, DATA_WIDTH bits
//   out_overflow  out  some step of the frame exceeded the maximum
//   out_underflow out  some step of the frame went below the minimum
// ---------------------------------------------------------------------------
module fxp_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int ACC_LEN    = 4,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_overflow,
    output logic                  out_underflow
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // An illegal parameter set elaborates nothing usable.
    if (ACC_LEN < 1 || FIXED_PNT < 0 || FIXED_PNT > DATA_WIDTH) begin : g_illegal_params
        illegal_fxp_accumulator_parameters u_illegal ();
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    // One accumulation step: returns {overflow, underflow, new_acc}.
    // The operands are sign-extended by one bit so that the exact sum cannot
    // wrap. Negating the most negative sample also stays in range. The top
    // two bits of the exact sum disagree only when the sum is outside the
    // DATA_WIDTH range. A sum that lands exactly on max or min leaves both
    // flags clear.
    function automatic logic [DATA_WIDTH+1:0] acc_step(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] sample,
        input logic                  sub
    );
        logic [DATA_WIDTH:0]   base_x;
        logic [DATA_WIDTH:0]   samp_x;
        logic [DATA_WIDTH:0]   oper;
        logic [DATA_WIDTH:0]   exact;
        logic                  ovf;
        logic                  unf;
        logic [DATA_WIDTH-1:0] res;
        base_x = {base[DATA_WIDTH-1], base};
        samp_x = {sample[DATA_WIDTH-1], sample};
        if (sub) begin
            oper = (~samp_x) + (DATA_WIDTH+1)'(1);
        end else begin
            oper = samp_x;
        end
        exact = base_x + oper;
        ovf   = ~exact[DATA_WIDTH] &  exact[DATA_WIDTH-1];
        unf   =  exact[DATA_WIDTH] & ~exact[DATA_WIDTH-1];
        if (SATURATE != 0 && ovf) begin
            res = ACC_MAX;
        end else if (SATURATE != 0 && unf) begin
            res = ACC_MIN;
        end else begin
            res = exact[DATA_WIDTH-1:0];
        end
        return {ovf, unf, res};
    endfunction

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  ovf_q,      ovf_d;       // running sticky flags of the frame
    logic                  unf_q,      unf_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;  // result captured on the final accept
    logic                  out_ovf_q,  out_ovf_d;
    logic                  out_unf_q,  out_unf_d;

    logic                  accept_s;
    logic [DATA_WIDTH-1:0] step_base_s;
    logic [DATA_WIDTH+1:0] step_s;
    logic                  step_ovf_s;
    logic                  step_unf_s;
    logic [DATA_WIDTH-1:0] step_acc_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  ovf_next_s;
    logic                  unf_next_s;

    assign in_ready      = (state_q != ST_HOLD);
    assign out_valid     = (state_q == ST_HOLD);
    assign out_data      = out_data_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;

    // Step datapath: a new frame starts from zero with cleared flags.
    always_comb begin
        accept_s = in_valid & in_ready;
        if (state_q == ST_IDLE) begin
            step_base_s = '0;
            cnt_next_s  = CNT_ONE;
        end else begin
            step_base_s = acc_q;
            cnt_next_s  = cnt_q + CNT_ONE;
        end
        step_s     = acc_step(step_base_s, in_data, in_sub);
        step_ovf_s = step_s[DATA_WIDTH+1];
        step_unf_s = step_s[DATA_WIDTH];
        step_acc_s = step_s[DATA_WIDTH-1:0];
        if (state_q == ST_IDLE) begin
            ovf_next_s = step_ovf_s;
            unf_next_s = step_unf_s;
        end else begin
            ovf_next_s = ovf_q | step_ovf_s;
            unf_next_s = unf_q | step_unf_s;
        end
    end

    // Next-state logic for the IDLE / ACCUM / HOLD frame sequencer.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_unf_d  = out_unf_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = step_acc_s;
                    cnt_d = cnt_next_s;
                    ovf_d = ovf_next_s;
                    unf_d = unf_next_s;
                    if (cnt_next_s == CNT_LAST) begin
                        // Final sample: publish the frame result for HOLD.
                        state_d    = ST_HOLD;
                        out_data_d = step_acc_s;
                        out_ovf_d  = ovf_next_s;
                        out_unf_d  = unf_next_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_unf_q  <= out_unf_d;
        end
    end

endmodule
